// File: rtl/sd_cmd_phy.sv
// SD CMD-line serial PHY: frames a 40-bit command token with CRC7 and end bit,
// shifts it out MSB first, then captures and checks the card's 48-bit response.
module sd_cmd_phy #(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCR_MIN      = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic        ack_in,
  input  logic [39:0] cmd_to_send,
  input  logic        cmd_pin_in,
  output logic        cmd_pin_out,
  output logic        cmd_oe,
  output logic        serial_ready,
  output logic        strobe_out,
  output logic        ack_out,
  output logic [39:0] response_out,
  output logic        crc_error,
  output logic        frame_error,
  output logic        resp_timeout
);

  localparam int CLOG = $clog2(RESP_TIMEOUT + 1);
  localparam int CW   = (CLOG > 6) ? CLOG : 6;
  localparam logic [CW-1:0] LAST_BIT  = CW'(47);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(RESP_TIMEOUT);
  localparam logic [CW-1:0] NCR_C     = CW'(NCR_MIN);

  typedef enum logic [2:0] {IDLE, SEND, RELEASE, WAIT_RESP, RECV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [47:0]   sreg;
  logic          armed;
  logic [47:0]   rx_word;
  logic [6:0]    tx_crc;
  logic [6:0]    rx_crc;
  logic          ack_in_unused;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // The same shift register serves transmit and receive; rx_word is the
  // value it would hold after taking the current line sample.
  assign rx_word       = {sreg[46:0], cmd_pin_in};
  assign tx_crc        = crc7(cmd_to_send);
  assign rx_crc        = crc7(rx_word[47:8]);
  assign ack_in_unused = ack_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sreg         <= '0;
      armed        <= 1'b1;
      cmd_pin_out  <= 1'b1;
      cmd_oe       <= 1'b0;
      serial_ready <= 1'b1;
      strobe_out   <= 1'b0;
      ack_out      <= 1'b0;
      response_out <= '0;
      crc_error    <= 1'b0;
      frame_error  <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A strobe still high from the previous transaction must drop
          // at least once while idle before a new command is accepted.
          if (!strobe_in) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed        <= 1'b0;
            sreg         <= {cmd_to_send[38:0], tx_crc, 1'b1, 1'b0};
            cmd_pin_out  <= cmd_to_send[39];
            cmd_oe       <= 1'b1;
            cnt          <= '0;
            serial_ready <= 1'b0;
            crc_error    <= 1'b0;
            frame_error  <= 1'b0;
            resp_timeout <= 1'b0;
            state        <= SEND;
          end
        end
        SEND: begin
          if (cnt == LAST_BIT) begin
            cmd_oe      <= 1'b0;
            cmd_pin_out <= 1'b1;
            cnt         <= '0;
            state       <= RELEASE;
          end else begin
            cmd_pin_out <= sreg[47];
            sreg        <= {sreg[46:0], 1'b0};
            cnt         <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          cnt   <= CW'(1);
          state <= WAIT_RESP;
        end
        WAIT_RESP: begin
          // cnt is the number of cycles since release for the sampled bit.
          if (cnt >= NCR_C && !cmd_pin_in) begin
            sreg  <= '0;
            cnt   <= CW'(1);
            state <= RECV;
          end else if (cnt == TIMEOUT_C) begin
            resp_timeout <= 1'b1;
            ack_out      <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECV: begin
          sreg <= rx_word;
          if (cnt == LAST_BIT) begin
            response_out <= rx_word[47:8];
            frame_error  <= rx_word[47] | rx_word[46] | ~rx_word[0];
            crc_error    <= (rx_word[7:1] != rx_crc);
            strobe_out   <= 1'b1;
            ack_out      <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!strobe_in) begin
            strobe_out   <= 1'b0;
            ack_out      <= 1'b0;
            response_out <= '0;
            crc_error    <= 1'b0;
            frame_error  <= 1'b0;
            resp_timeout <= 1'b0;
            serial_ready <= 1'b1;
            cnt          <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: wire frames, card replies, timeout, framing
// and CRC errors, Ncr blanking window and mid-frame reset.
module tb_sd_cmd_phy;

  logic        clock = 1'b0;
  logic        reset;
  logic        strobe_in;
  logic        ack_in;
  logic [39:0] cmd_to_send;
  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic        cmd_oe;
  logic        serial_ready;
  logic        strobe_out;
  logic        ack_out;
  logic [39:0] response_out;
  logic        crc_error;
  logic        frame_error;
  logic        resp_timeout;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [39:0] CMD0  = 40'h40_0000_0000;
  localparam logic [47:0] CMD0F = 48'h40_0000_0000_95;
  localparam logic [39:0] CMD8  = 40'h48_0000_01AA;
  localparam logic [47:0] CMD8F = 48'h48_0000_01AA_87;
  localparam logic [39:0] R7    = 40'h08_0000_01AA;

  logic [47:0] r7_frame;

  sd_cmd_phy #(.RESP_TIMEOUT(64), .NCR_MIN(2)) dut (
    .clock(clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
    .cmd_to_send(cmd_to_send), .cmd_pin_in(cmd_pin_in), .cmd_pin_out(cmd_pin_out),
    .cmd_oe(cmd_oe), .serial_ready(serial_ready), .strobe_out(strobe_out),
    .ack_out(ack_out), .response_out(response_out), .crc_error(crc_error),
    .frame_error(frame_error), .resp_timeout(resp_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CRC7 (x^7+x^3+1), bitwise long division, MSB first.
  function automatic logic [6:0] ref_crc7(input logic [39:0] d);
    logic [7:0] rem;
    rem = '0;
    for (int i = 39; i >= 0; i--) begin
      rem = {rem[6:0], d[i]};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    for (int i = 0; i < 7; i++) begin
      rem = {rem[6:0], 1'b0};
      if (rem[7]) rem = rem ^ 8'h89;
    end
    return rem[6:0];
  endfunction

  // Called at a negedge; returns at the negedge of the release cycle.
  task automatic send_frame(input logic [39:0] cmd, input logic [47:0] exp,
                            input string tag, input int drop_at);
    logic [47:0] wire_f;
    int          oe_cnt;
    cmd_to_send = cmd;
    strobe_in   = 1'b1;
    @(posedge clock);
    wire_f = '0;
    oe_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clock);
      if (k == 0) begin
        check({tag, "_ready_low"}, 64'(serial_ready), 64'd0);
        cmd_to_send = ~cmd;
      end
      if (k == drop_at) strobe_in = 1'b0;
      wire_f[47-k] = cmd_pin_out;
      oe_cnt += int'(cmd_oe);
    end
    @(negedge clock);
    oe_cnt += int'(cmd_oe);
    check({tag, "_frame"}, 64'(wire_f), 64'(exp));
    check({tag, "_oe_len"}, 64'(oe_cnt), 64'd48);
    check({tag, "_release_pin"}, 64'(cmd_pin_out), 64'd1);
  endtask

  // Starts at the release-cycle negedge (j=0); start bit driven in cycle j=delay.
  // Returns at negedge j=delay+48, the first cycle the result is visible.
  task automatic card_reply(input logic [47:0] resp, input int delay, input bit early0);
    for (int j = 1; j < delay; j++) begin
      @(negedge clock);
      cmd_pin_in = (early0 && j == 1) ? 1'b0 : 1'b1;
    end
    @(negedge clock);
    cmd_pin_in = resp[47];
    for (int i = 46; i >= 0; i--) begin
      @(negedge clock);
      cmd_pin_in = resp[i];
    end
    @(negedge clock);
    cmd_pin_in = 1'b1;
  endtask

  task automatic finish_txn(input string tag);
    strobe_in = 1'b0;
    @(negedge clock);
    check({tag, "_ack_clr"}, 64'(ack_out), 64'd0);
    check({tag, "_strobe_clr"}, 64'(strobe_out), 64'd0);
    check({tag, "_ready_back"}, 64'(serial_ready), 64'd1);
    @(negedge clock);
  endtask

  task automatic check_done(input string tag, input logic strb, input logic [39:0] resp,
                            input logic cerr, input logic ferr, input logic tout);
    check({tag, "_ack"}, 64'(ack_out), 64'd1);
    check({tag, "_strobe"}, 64'(strobe_out), 64'(strb));
    check({tag, "_resp"}, 64'(response_out), 64'(resp));
    check({tag, "_crc_err"}, 64'(crc_error), 64'(cerr));
    check({tag, "_frame_err"}, 64'(frame_error), 64'(ferr));
    check({tag, "_timeout"}, 64'(resp_timeout), 64'(tout));
  endtask

  initial begin
    reset = 1'b1; strobe_in = 1'b0; ack_in = 1'b0;
    cmd_to_send = '0; cmd_pin_in = 1'b1;
    r7_frame = {R7, ref_crc7(R7), 1'b1};
    repeat (3) @(negedge clock);
    check("rst_pin", 64'(cmd_pin_out), 64'd1);
    check("rst_oe", 64'(cmd_oe), 64'd0);
    check("rst_ready", 64'(serial_ready), 64'd1);
    check("rst_strobe", 64'(strobe_out), 64'd0);
    check("rst_ack", 64'(ack_out), 64'd0);
    check("rst_resp", 64'(response_out), 64'd0);
    check("rst_flags", 64'({crc_error, frame_error, resp_timeout}), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // CMD0, no card reply: timeout after RESP_TIMEOUT+1 cycles
    send_frame(CMD0, CMD0F, "cmd0", -1);
    repeat (64) @(negedge clock);
    check("to_ack_early", 64'(ack_out), 64'd0);
    @(negedge clock);
    check_done("to", 1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    finish_txn("to");

    // CMD8 with valid R7
    send_frame(CMD8, CMD8F, "cmd8", -1);
    card_reply(r7_frame, 3, 1'b0);
    ack_in = 1'b1;
    check_done("r7", 1'b1, R7, 1'b0, 1'b0, 1'b0);
    finish_txn("r7");
    ack_in = 1'b0;

    // R7 with argument bit 0 flipped
    send_frame(CMD8, CMD8F, "cmd8b", -1);
    card_reply(r7_frame ^ 48'h00_0000_0001_00, 3, 1'b0);
    check_done("crcbad", 1'b1, 40'h08_0000_01AB, 1'b1, 1'b0, 1'b0);
    finish_txn("crcbad");

    // End bit 0; strobe dropped mid-SEND, transaction still completes
    send_frame(CMD8, CMD8F, "cmd8c", 10);
    card_reply(r7_frame & ~48'h1, 3, 1'b0);
    check_done("endbad", 1'b1, R7, 1'b0, 1'b1, 1'b0);
    finish_txn("endbad");

    // Early 0 inside the Ncr window is ignored; real start bit at j=5
    send_frame(CMD8, CMD8F, "cmd8d", -1);
    card_reply(r7_frame, 5, 1'b1);
    check_done("early", 1'b1, R7, 1'b0, 1'b0, 1'b0);
    finish_txn("early");

    // Reset at SEND bit 20, then a fresh command
    cmd_to_send = CMD0;
    strobe_in   = 1'b1;
    @(posedge clock);
    repeat (21) @(negedge clock);
    check("midrst_bit20", 64'(cmd_pin_out), 64'(CMD0F[27]));
    check("midrst_oe_before", 64'(cmd_oe), 64'd1);
    reset = 1'b1;
    strobe_in = 1'b0;
    @(negedge clock);
    check("midrst_oe", 64'(cmd_oe), 64'd0);
    check("midrst_pin", 64'(cmd_pin_out), 64'd1);
    check("midrst_ready", 64'(serial_ready), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    send_frame(CMD8, CMD8F, "post_rst", -1);
    card_reply(r7_frame, 3, 1'b0);
    check_done("post_rst", 1'b1, R7, 1'b0, 1'b0, 1'b0);
    finish_txn("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
- Serial physical stage directly downstream of the SD host command controller.
- Accepts a 40-bit command token (start, transmission, index, argument) and appends CRC7 and the end bit.
- Shifts the 48-bit frame out on the CMD line, one bit per clock, then releases the line.
- Captures the card's 48-bit response, checks framing and CRC7, and returns the 40-bit response token to the controller over a strobe/ack handshake.

Parameters:
- RESP_TIMEOUT, 64, max clocks from line release to the response start bit (Ncr) before timeout.
- NCR_MIN, 2, clocks after line release during which cmd_pin_in is ignored.

Ports:
- clock  in  1  block clock; one CMD bit per cycle.
- reset  in  1  synchronous, active-high.
- strobe_in  in  1  controller command valid; held high while the command is outstanding.
- ack_in  in  1  controller acknowledge; informational only, no effect on the FSM.
- cmd_to_send  in  40  command token, bit 39 first on the wire.
- cmd_pin_in  in  1  sampled CMD line.
- cmd_pin_out  out  1  driven CMD level.
- cmd_oe  out  1  CMD output enable.
- serial_ready  out  1  high only in IDLE.
- strobe_out  out  1  response token valid.
- ack_out  out  1  transaction finished (response or timeout).
- response_out  out  40  received bits 47..8.
- crc_error  out  1  response CRC7 mismatch.
- frame_error  out  1  bad start, transmission or end bit.
- resp_timeout  out  1  no start bit within RESP_TIMEOUT.

Behaviour:
- Reset and IDLE values:
  - cmd_pin_out=1, cmd_oe=0, serial_ready=1.
  - strobe_out=0, ack_out=0, response_out=0.
  - All error flags 0; counters 0.
  - Reset has priority in any state and aborts a frame mid-shift; the line is released the next cycle.
- FSM states: IDLE, SEND, RELEASE, WAIT_RESP, RECV, DONE.
- IDLE -> SEND:
  - Triggered by strobe_in=1 at edge N.
  - On that edge: latch cmd_to_send; compute CRC7 (x^7+x^3+1, init 0) over the 40 bits, MSB first; load shift register {cmd, crc7, 1'b1}.
  - The CRC is computed combinationally over the latched token or serially during shift; either way it is complete before bit 8 is sent.
  - Clear error flags; serial_ready falls.
- SEND:
  - cmd_oe=1; cmd_pin_out = frame[47-k] on cycle N+1+k, k=0..47.
  - The end bit goes out on N+48.
- RELEASE:
  - One cycle: cmd_oe=0, cmd_pin_out=1.
  - Start the wait counter at 0.
- WAIT_RESP:
  - Counter increments every cycle.
  - cmd_pin_in is ignored while counter < NCR_MIN.
  - First sample of cmd_pin_in=0 at counter >= NCR_MIN is response bit 47; go to RECV.
  - Counter reaching RESP_TIMEOUT with no start bit: resp_timeout=1, go to DONE.
- RECV:
  - Shift 47 further bits, MSB first, into a 48-bit register.
  - Run CRC7 over received bits 47..8.
  - After bit 0: response_out = bits 47..8.
  - frame_error=1 if bit47!=0, bit46!=0 or bit0!=1.
  - crc_error=1 if bits 7..1 != computed CRC7.
  - Go to DONE.
  - Total receive length is fixed at 48 bits; 136-bit R2 responses are out of scope.
- DONE:
  - ack_out=1.
  - strobe_out=1 only if resp_timeout=0; error flags and response_out held stable.
  - Stay in DONE until strobe_in=0, then go to IDLE on the next edge with all handshake outputs cleared.
- Boundary conditions:
  - strobe_in dropping during SEND, WAIT_RESP or RECV does not abort the transaction; the abandonment is observed only in DONE.
  - strobe_in still high on the same edge DONE exits is not re-accepted; a new transaction requires strobe_in low for at least one cycle in IDLE.
  - cmd_to_send changes after the latch edge have no effect.

Test Plan:
- CMD0, cmd_to_send=40'h40_0000_0000 -> wire frame 48'h40_0000_0000_95 on cycles N+1..N+48; cmd_oe high for exactly 48 cycles.
- CMD8, cmd_to_send=40'h48_0000_01AA -> wire 48'h48_0000_01AA_87; card model replies 3 cycles after release with a valid R7 (CRC from the bench model) -> strobe_out=ack_out=1, response_out equals reply bits 47..8, all error flags 0.
- Same as the CMD8 case, but one argument bit of the response is flipped -> crc_error=1, strobe_out=1, frame_error=0.
- No card reply (cmd_pin_in held 1) -> resp_timeout=1, ack_out=1, strobe_out=0 exactly RESP_TIMEOUT+1 cycles after release; returns to IDLE one cycle after strobe_in falls.
- Response with end bit 0, then a second case with a 0 driven on the line at counter=1 (inside the NCR_MIN window) -> first: frame_error=1; second: the early 0 is ignored and reception starts at the later valid start bit.
- reset asserted at SEND bit 20 -> next cycle cmd_oe=0, cmd_pin_out=1, serial_ready=1; a fresh strobe_in then produces a complete correct frame.
